// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, funct codes, ALU control codes, datapath
// select encodings and the main-control state encoding.
package cpu_defs_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  // ALU control codes seen by the ALU
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // ALUOp: how the ALU control decoder should interpret the request
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Main control states; encodings 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    IEXEC  = 4'd8,
    IWB    = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: turns the main FSM's ALUOp request plus the
// instruction funct field into the 4-bit ALU operation code.
module alu_ctrl_dec
  import cpu_defs_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [3:0] ALUCtrl
);

  // Select ALU operation; anything not explicitly a subtract is an add
  always_comb begin
    ALUCtrl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUCtrl = ALU_ADD;
      ALUOP_SUB: ALUCtrl = ALU_SUB;
      ALUOP_FUNCT: begin
        if (Funct == FN_SUB) begin
          ALUCtrl = ALU_SUB;
        end else begin
          ALUCtrl = ALU_ADD;
        end
      end
      default: ALUCtrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM. Sequences each instruction through
// fetch/decode/execute/memory/writeback, drives the datapath selects and
// write enables, and counts retired instructions. Outputs are decoded from
// the state register; Reset forces every output to its idle value in the
// same cycle so an aborted instruction never writes anything.
module multicycle_control
  import cpu_defs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic [3:0]       ALUCtrl,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  state_t           state_r;
  state_t           state_next_s;
  logic [1:0]       aluop_s;
  logic             retire_s;
  logic [CNT_W-1:0] count_r;

  alu_ctrl_dec u_alu_ctrl_dec (
    .ALUOp  (aluop_s),
    .Funct  (Funct),
    .ALUCtrl(ALUCtrl)
  );

  assign InstrCount = count_r;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_r <= '0;
    end else if (retire_s) begin
      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  // Next-state and output decode; idle values first, reset keeps them
  always_comb begin
    state_next_s = FETCH;
    aluop_s      = ALUOP_ADD;
    retire_s     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REGB;
    PCSource     = PCSRC_ALU;
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    IllegalOp    = 1'b0;
    if (Reset) begin
      state_next_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = MemReady;
          PCWrite = MemReady;
          if (MemReady) begin
            state_next_s = DECODE;
          end else begin
            state_next_s = FETCH;
          end
        end
        DECODE: begin
          // Branch target is precomputed here while the opcode is decoded
          ALUSrcB = SRCB_IMM_SH2;
          case (Opcode)
            OP_LW, OP_SW: state_next_s = MEMADR;
            OP_ADDI:      state_next_s = IEXEC;
            OP_BEQ:       state_next_s = BRANCH;
            OP_J:         state_next_s = JUMP;
            OP_RTYPE: begin
              if (Funct == FN_ADD) begin
                state_next_s = EXEC;
              end else begin
                IllegalOp    = 1'b1;
                state_next_s = FETCH;
              end
            end
            default: begin
              IllegalOp    = 1'b1;
              state_next_s = FETCH;
            end
          endcase
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          if (Opcode == OP_SW) begin
            state_next_s = MEMWR;
          end else begin
            state_next_s = MEMRD;
          end
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (MemReady) begin
            state_next_s = MEMWB;
          end else begin
            state_next_s = MEMRD;
          end
        end
        MEMWB: begin
          RegWrite     = 1'b1;
          MemtoReg     = 1'b1;
          retire_s     = 1'b1;
          state_next_s = FETCH;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (MemReady) begin
            retire_s     = 1'b1;
            state_next_s = FETCH;
          end else begin
            state_next_s = MEMWR;
          end
        end
        EXEC: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = SRCB_REGB;
          aluop_s      = ALUOP_FUNCT;
          state_next_s = RWB;
        end
        RWB: begin
          RegWrite     = 1'b1;
          RegDst       = 1'b1;
          retire_s     = 1'b1;
          state_next_s = FETCH;
        end
        IEXEC: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = SRCB_IMM;
          state_next_s = IWB;
        end
        IWB: begin
          RegWrite     = 1'b1;
          retire_s     = 1'b1;
          state_next_s = FETCH;
        end
        BRANCH: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = SRCB_REGB;
          aluop_s      = ALUOP_SUB;
          PCSource     = PCSRC_ALUOUT;
          PCWrite      = Zero;
          retire_s     = 1'b1;
          state_next_s = FETCH;
        end
        JUMP: begin
          PCSource     = PCSRC_JUMP;
          PCWrite      = 1'b1;
          retire_s     = 1'b1;
          state_next_s = FETCH;
        end
        default: begin
          state_next_s = FETCH;
        end
      endcase
    end
  end

endmodule
